uart_rx_ctrl: RTL and testbench

- Sequences and buffers the UART receive path. It sits between the UART_RX deserializer and the consuming logic.
- Tracks frame progress from the receiver's busy, valid and framing-error strobes, commits good bytes into a small FIFO and presents them on a valid/ready stream.
- Counts overrun and framing errors, and re-arms reception after an error only once the line has been idle for one bit time.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_ctrl_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_pkg;

  localparam int UART_WIDTH        = 8;
  localparam int UART_CLKS_PER_BIT = 10417;
  // Idle line length, in bit times, that triggers the optional receive timeout
  localparam int TIMEOUT_BITS      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    COMMIT  = 2'd2,
    RECOVER = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Valid/ready byte stream from the receive controller to its consumer.
interface uart_rx_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO holding received bytes.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [WIDTH-1:0]       rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because reads are gated by level
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-path sequencer: follows UART_RX strobes, buffers good bytes in a
// FIFO, counts overrun/framing errors and waits one idle bit time after an
// error before accepting another frame.
// Optional receive timeout pulse is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH        = UART_WIDTH,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   rx_line,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_busy,
  input  logic                   rx_frame_err,
  uart_rx_ctrl_if.master         m,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       overrun_cnt,
  output logic [CNT_W-1:0]       ferr_cnt,
  input  logic                   clr_stats
`ifdef UART_RX_CTRL_TIMEOUT_EN
  ,
  output logic                   rx_timeout
`endif
);

  localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);

  ctrl_state_t          state;
  ctrl_state_t          state_next;
  logic [WIDTH-1:0]     data_q;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 latch_en;
  logic                 ferr_hit;
  logic                 commit;
  logic                 recover_done;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 overrun_hit;
  logic [WIDTH-1:0]     fifo_head;

  assign recover_done = rx_line & (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
  assign fifo_pop     = m.m_ready & ~fifo_empty;
  assign overrun_hit  = commit & fifo_full & ~fifo_pop;

  assign m.m_valid = ~fifo_empty;
  assign m.m_data  = fifo_head;

  uart_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (commit),
    .pop   (m.m_ready),
    .wdata (data_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .rdata (fifo_head)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-state strobes; a framing error beats a coincident byte
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    ferr_hit   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (en && rx_busy) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (rx_frame_err) begin
          state_next = RECOVER;
          ferr_hit   = 1'b1;
        end else if (rx_valid) begin
          state_next = COMMIT;
          latch_en   = 1'b1;
        end else if (!rx_busy) begin
          state_next = IDLE;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      RECOVER: begin
        if (recover_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Hold the received byte for the commit cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (latch_en) begin
      data_q <= rx_data;
    end
  end

  // Idle-line bit timer used while recovering; any low sample restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (state != RECOVER || !rx_line) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Saturating error counters; a clear takes priority over an increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt <= '0;
      ferr_cnt    <= '0;
    end else if (clr_stats) begin
      overrun_cnt <= '0;
      ferr_cnt    <= '0;
    end else begin
      if (overrun_hit && overrun_cnt != '1) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
      if (ferr_hit && ferr_cnt != '1) begin
        ferr_cnt <= ferr_cnt + CNT_W'(1);
      end
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_armed;
  logic             busy_q;
  logic             busy_rise;
  logic             push_ok;

  assign busy_rise = rx_busy & ~busy_q;
  assign push_ok   = commit & ~overrun_hit;

  // Idle timeout: fires once per committed byte while data sits unread
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt    <= '0;
      tmo_armed  <= 1'b1;
      busy_q     <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      busy_q     <= rx_busy;
      rx_timeout <= 1'b0;
      if (busy_rise || fifo_empty) begin
        tmo_cnt <= '0;
      end else if (state == IDLE && rx_line && tmo_armed) begin
        if (tmo_cnt == TMO_W'(TMO_LIMIT - 1)) begin
          rx_timeout <= 1'b1;
          tmo_armed  <= 1'b0;
          tmo_cnt    <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
      if (push_ok || fifo_empty) begin
        tmo_armed <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a short bit time.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CLKS  = 16;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   en = 1'b0;
  logic                   rx_line = 1'b1;
  logic [WIDTH-1:0]       rx_data = '0;
  logic                   rx_valid = 1'b0;
  logic                   rx_busy = 1'b0;
  logic                   rx_frame_err = 1'b0;
  logic                   clr_stats = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0]       overrun_cnt;
  logic [CNT_W-1:0]       ferr_cnt;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_b;

  uart_rx_ctrl_if #(.WIDTH(WIDTH)) m_if ();

`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic rx_timeout;
  int   tmo_pulses = 0;
  int   tmo_base;
`endif

  uart_rx_ctrl #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CLKS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rx_line      (rx_line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .m            (m_if),
    .fifo_level   (fifo_level),
    .overrun_cnt  (overrun_cnt),
    .ferr_cnt     (ferr_cnt),
    .clr_stats    (clr_stats)
`ifdef UART_RX_CTRL_TIMEOUT_EN
    ,
    .rx_timeout   (rx_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Stream monitor: every accepted byte must match the scoreboard head
  always @(negedge clk) begin
    if (reset && m_if.m_valid && m_if.m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL stream_unexpected: got 0x%0h, required no byte", m_if.m_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (m_if.m_data !== exp_b) begin
          errors++;
          $display("[TB] FAIL stream_data: got 0x%0h, required 0x%0h", m_if.m_data, exp_b);
        end
      end
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  // Timeout pulse counter
  always @(negedge clk) begin
    if (rx_timeout) tmo_pulses++;
  end
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // One received frame: busy, strobe with the byte, then the commit cycle
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit store, input bit pop_at_commit);
    rx_busy = 1'b1;
    tick();
    tick();
    rx_valid = 1'b1;
    rx_data  = d;
    rx_busy  = 1'b0;
    if (store) exp_q.push_back(d);
    tick();
    rx_valid = 1'b0;
    if (pop_at_commit) m_if.m_ready = 1'b1;
    tick();
    if (pop_at_commit) m_if.m_ready = 1'b0;
  endtask

  // Bad stop bit followed by exactly one idle bit time
  task automatic frameError();
    rx_busy = 1'b1;
    tick();
    rx_busy      = 1'b0;
    rx_frame_err = 1'b1;
    rx_line      = 1'b0;
    tick();
    rx_frame_err = 1'b0;
    rx_line      = 1'b1;
    repeat (CLKS) tick();
  endtask

  task automatic drain(input string name);
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 16 && fifo_level != 0; i++) tick();
    m_if.m_ready = 1'b0;
    checkOutput(name, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_if.m_data), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_cnt), 32'd0);
    checkOutput("rst_ferr", 32'(ferr_cnt), 32'd0);
    reset = 1'b1;
    en    = 1'b1;
    tick();

    // Single byte with consumer ready: two-clock latency then immediate pop
    m_if.m_ready = 1'b1;
    rx_busy = 1'b1;
    tick();
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    rx_busy  = 1'b0;
    exp_q.push_back(8'hAA);
    tick();
    rx_valid = 1'b0;
    checkOutput("lat_valid_1clk", 32'(m_if.m_valid), 32'd0);
    tick();
    checkOutput("lat_valid_2clk", 32'(m_if.m_valid), 32'd1);
    checkOutput("lat_data", 32'(m_if.m_data), 32'hAA);
    tick();
    checkOutput("lat_level_after_pop", 32'(fifo_level), 32'd0);
    m_if.m_ready = 1'b0;

    // Five bytes into a four-entry FIFO: last one overruns
    for (int i = 1; i <= 5; i++) applyStimulus(WIDTH'(i), i <= 4, 1'b0);
    checkOutput("ovr_level", 32'(fifo_level), 32'd4);
    checkOutput("ovr_count", 32'(overrun_cnt), 32'd1);
    checkOutput("ovr_head", 32'(m_if.m_data), 32'h01);
    drain("ovr_drain");

    // Framing error with a coincident byte; recovery needs a full idle bit
    rx_busy = 1'b1;
    tick();
    rx_busy      = 1'b0;
    rx_frame_err = 1'b1;
    rx_valid     = 1'b1;
    rx_data      = 8'hEE;
    rx_line      = 1'b0;
    tick();
    rx_frame_err = 1'b0;
    rx_valid     = 1'b0;
    checkOutput("ferr_count", 32'(ferr_cnt), 32'd1);
    checkOutput("ferr_state", 32'(dut.state), 32'(RECOVER));
    rx_busy = 1'b1;
    repeat (4) tick();
    checkOutput("ferr_busy_ignored", 32'(dut.state), 32'(RECOVER));
    rx_busy = 1'b0;
    rx_line = 1'b1;
    repeat (CLKS - 2) tick();
    rx_line = 1'b0;
    tick();
    checkOutput("ferr_restart", 32'(dut.state), 32'(RECOVER));
    rx_line = 1'b1;
    repeat (CLKS - 1) tick();
    checkOutput("ferr_not_yet_idle", 32'(dut.state), 32'(RECOVER));
    tick();
    checkOutput("ferr_idle", 32'(dut.state), 32'(IDLE));
    checkOutput("ferr_no_write", 32'(fifo_level), 32'd0);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    checkOutput("ferr_resume_level", 32'(fifo_level), 32'd1);
    checkOutput("ferr_resume_data", 32'(m_if.m_data), 32'h5A);
    drain("ferr_drain");

    // Full FIFO with a pop during commit: byte accepted, no overrun
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checkOutput("clr_overrun", 32'(overrun_cnt), 32'd0);
    checkOutput("clr_ferr", 32'(ferr_cnt), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0);
    checkOutput("full_level", 32'(fifo_level), 32'd4);
    applyStimulus(8'h14, 1'b1, 1'b1);
    checkOutput("full_pushpop_level", 32'(fifo_level), 32'd4);
    checkOutput("full_pushpop_overrun", 32'(overrun_cnt), 32'd0);
    drain("full_drain");

    // Framing error counter saturation and clear priority
    for (int i = 0; i < 256; i++) frameError();
    checkOutput("ferr_saturate", 32'(ferr_cnt), 32'd255);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checkOutput("ferr_cleared", 32'(ferr_cnt), 32'd0);
    rx_busy = 1'b1;
    tick();
    rx_busy      = 1'b0;
    rx_frame_err = 1'b1;
    rx_line      = 1'b0;
    clr_stats    = 1'b1;
    tick();
    rx_frame_err = 1'b0;
    clr_stats    = 1'b0;
    rx_line      = 1'b1;
    repeat (CLKS) tick();
    checkOutput("clr_wins", 32'(ferr_cnt), 32'd0);
    frameError();
    checkOutput("ferr_after_clr", 32'(ferr_cnt), 32'd1);

    // Enable handling: ignored while low, but an open frame still completes
    en = 1'b0;
    applyStimulus(8'h77, 1'b0, 1'b0);
    checkOutput("en_low_ignored", 32'(fifo_level), 32'd0);
    en = 1'b1;
    rx_busy = 1'b1;
    tick();
    en       = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    rx_busy  = 1'b0;
    exp_q.push_back(8'h3C);
    tick();
    rx_valid = 1'b0;
    tick();
    checkOutput("en_fall_level", 32'(fifo_level), 32'd1);
    checkOutput("en_fall_data", 32'(m_if.m_data), 32'h3C);
    applyStimulus(8'h99, 1'b0, 1'b0);
    checkOutput("en_low_still_one", 32'(fifo_level), 32'd1);
    drain("en_drain");
    en = 1'b1;

    // Ready with an empty FIFO does nothing
    m_if.m_ready = 1'b1;
    repeat (3) tick();
    checkOutput("ready_empty_level", 32'(fifo_level), 32'd0);
    checkOutput("ready_empty_valid", 32'(m_if.m_valid), 32'd0);
    m_if.m_ready = 1'b0;

    // Asynchronous reset in the middle of a frame
    applyStimulus(8'h21, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    rx_busy = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(m_if.m_data), 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_ferr", 32'(ferr_cnt), 32'd0);
    checkOutput("mid_rst_state", 32'(dut.state), 32'(IDLE));
    exp_q.delete();
    rx_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(8'h5C, 1'b1, 1'b0);
    checkOutput("post_rst_level", 32'(fifo_level), 32'd1);
    checkOutput("post_rst_data", 32'(m_if.m_data), 32'h5C);
    drain("post_rst_drain");

`ifdef UART_RX_CTRL_TIMEOUT_EN
    // Timeout fires once per stored byte and never on an empty FIFO
    tmo_base = tmo_pulses;
    applyStimulus(8'h42, 1'b1, 1'b0);
    repeat (TIMEOUT_BITS * CLKS - 5) tick();
    checkOutput("tmo_early", 32'(tmo_pulses - tmo_base), 32'd0);
    repeat (20) tick();
    checkOutput("tmo_fired", 32'(tmo_pulses - tmo_base), 32'd1);
    repeat (TIMEOUT_BITS * CLKS + 20) tick();
    checkOutput("tmo_once", 32'(tmo_pulses - tmo_base), 32'd1);
    drain("tmo_drain");
    repeat (TIMEOUT_BITS * CLKS + 20) tick();
    checkOutput("tmo_empty", 32'(tmo_pulses - tmo_base), 32'd1);
`endif

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
